// File: rtl/sha2_k_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sha2_k_sequencer_if : control/data bundle for the K sequencer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface sha2_k_sequencer_if #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 7
);
   logic              start;
   logic              stall;
   logic              abort;
   logic              rd;
   logic [IDX_W-1:0]  addr;
   logic [WORD_W-1:0] k_out;
   logic [IDX_W-1:0]  round_idx;
   logic              k_valid;
   logic              rd_valid;
   logic              busy;
   logic              done;

   modport master (
      output start, stall, abort, rd, addr,
      input  k_out, round_idx, k_valid, rd_valid, busy, done
   );

   modport slave (
      input  start, stall, abort, rd, addr,
      output k_out, round_idx, k_valid, rd_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/sha2_k_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sha2_k_sequencer : SHA-256/512 round-constant streamer + ROM port |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sha2_k_sequencer #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   sha2_k_sequencer_if.slave bus
);
   localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ROUNDS - 1);

   generate
      if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
         $error("sha2_k_sequencer: WORD_W must be 32 or 64");
      end
      if ((1 << IDX_W) < ROUNDS) begin : g_bad_idx_w
         $error("sha2_k_sequencer: IDX_W too narrow for ROUNDS");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // The K256 table is the upper half of K512[0..63], so one ROM serves both widths.
   function automatic logic [WORD_W-1:0] k_lookup(input logic [IDX_W-1:0] i);
      logic [63:0] k;
      case (7'(i))
         7'd0 : k = 64'h428a2f98d728ae22;
         7'd1 : k = 64'h7137449123ef65cd;
         7'd2 : k = 64'hb5c0fbcfec4d3b2f;
         7'd3 : k = 64'he9b5dba58189dbbc;
         7'd4 : k = 64'h3956c25bf348b538;
         7'd5 : k = 64'h59f111f1b605d019;
         7'd6 : k = 64'h923f82a4af194f9b;
         7'd7 : k = 64'hab1c5ed5da6d8118;
         7'd8 : k = 64'hd807aa98a3030242;
         7'd9 : k = 64'h12835b0145706fbe;
         7'd10: k = 64'h243185be4ee4b28c;
         7'd11: k = 64'h550c7dc3d5ffb4e2;
         7'd12: k = 64'h72be5d74f27b896f;
         7'd13: k = 64'h80deb1fe3b1696b1;
         7'd14: k = 64'h9bdc06a725c71235;
         7'd15: k = 64'hc19bf174cf692694;
         7'd16: k = 64'he49b69c19ef14ad2;
         7'd17: k = 64'hefbe4786384f25e3;
         7'd18: k = 64'h0fc19dc68b8cd5b5;
         7'd19: k = 64'h240ca1cc77ac9c65;
         7'd20: k = 64'h2de92c6f592b0275;
         7'd21: k = 64'h4a7484aa6ea6e483;
         7'd22: k = 64'h5cb0a9dcbd41fbd4;
         7'd23: k = 64'h76f988da831153b5;
         7'd24: k = 64'h983e5152ee66dfab;
         7'd25: k = 64'ha831c66d2db43210;
         7'd26: k = 64'hb00327c898fb213f;
         7'd27: k = 64'hbf597fc7beef0ee4;
         7'd28: k = 64'hc6e00bf33da88fc2;
         7'd29: k = 64'hd5a79147930aa725;
         7'd30: k = 64'h06ca6351e003826f;
         7'd31: k = 64'h142929670a0e6e70;
         7'd32: k = 64'h27b70a8546d22ffc;
         7'd33: k = 64'h2e1b21385c26c926;
         7'd34: k = 64'h4d2c6dfc5ac42aed;
         7'd35: k = 64'h53380d139d95b3df;
         7'd36: k = 64'h650a73548baf63de;
         7'd37: k = 64'h766a0abb3c77b2a8;
         7'd38: k = 64'h81c2c92e47edaee6;
         7'd39: k = 64'h92722c851482353b;
         7'd40: k = 64'ha2bfe8a14cf10364;
         7'd41: k = 64'ha81a664bbc423001;
         7'd42: k = 64'hc24b8b70d0f89791;
         7'd43: k = 64'hc76c51a30654be30;
         7'd44: k = 64'hd192e819d6ef5218;
         7'd45: k = 64'hd69906245565a910;
         7'd46: k = 64'hf40e35855771202a;
         7'd47: k = 64'h106aa07032bbd1b8;
         7'd48: k = 64'h19a4c116b8d2d0c8;
         7'd49: k = 64'h1e376c085141ab53;
         7'd50: k = 64'h2748774cdf8eeb99;
         7'd51: k = 64'h34b0bcb5e19b48a8;
         7'd52: k = 64'h391c0cb3c5c95a63;
         7'd53: k = 64'h4ed8aa4ae3418acb;
         7'd54: k = 64'h5b9cca4f7763e373;
         7'd55: k = 64'h682e6ff3d6b2b8a3;
         7'd56: k = 64'h748f82ee5defb2fc;
         7'd57: k = 64'h78a5636f43172f60;
         7'd58: k = 64'h84c87814a1f0ab72;
         7'd59: k = 64'h8cc702081a6439ec;
         7'd60: k = 64'h90befffa23631e28;
         7'd61: k = 64'ha4506cebde82bde9;
         7'd62: k = 64'hbef9a3f7b2c67915;
         7'd63: k = 64'hc67178f2e372532b;
         7'd64: k = 64'hca273eceea26619c;
         7'd65: k = 64'hd186b8c721c0c207;
         7'd66: k = 64'heada7dd6cde0eb1e;
         7'd67: k = 64'hf57d4f7fee6ed178;
         7'd68: k = 64'h06f067aa72176fba;
         7'd69: k = 64'h0a637dc5a2c898a6;
         7'd70: k = 64'h113f9804bef90dae;
         7'd71: k = 64'h1b710b35131c471b;
         7'd72: k = 64'h28db77f523047d84;
         7'd73: k = 64'h32caab7b40c72493;
         7'd74: k = 64'h3c9ebe0a15c9bebc;
         7'd75: k = 64'h431d67c49c100d4c;
         7'd76: k = 64'h4cc5d4becb3e42b6;
         7'd77: k = 64'h597f299cfc657e2a;
         7'd78: k = 64'h5fcb6fab3ad6faec;
         7'd79: k = 64'h6c44198c4a475817;
         default: k = 64'h0;
      endcase
      if (32'(i) >= 32'(ROUNDS)) begin
         k = 64'h0;
      end
      return WORD_W'(k >> (64 - WORD_W));
   endfunction

   state_t            r_state;
   logic [WORD_W-1:0] r_k_out;
   logic [IDX_W-1:0]  r_round_idx;
   logic              r_k_valid;
   logic              r_rd_valid;
   logic              r_busy;
   logic              r_done;
   logic [IDX_W-1:0]  w_rom_idx;
   logic [WORD_W-1:0] w_rom_k;

   // Single ROM port: next round while streaming, K[0] on start, else the debug address.
   always_comb begin
      if (r_state == S_RUN) begin
         w_rom_idx = r_round_idx + IDX_W'(1);
      end else if (bus.start) begin
         w_rom_idx = '0;
      end else begin
         w_rom_idx = bus.addr;
      end
   end

   assign w_rom_k = k_lookup(w_rom_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k_out     <= '0;
         r_round_idx <= '0;
         r_k_valid   <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state     <= S_RUN;
                  r_k_out     <= w_rom_k;
                  r_round_idx <= '0;
                  r_k_valid   <= 1'b1;
                  r_busy      <= 1'b1;
               end else if (bus.rd) begin
                  r_k_out    <= w_rom_k;
                  r_rd_valid <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  r_state   <= S_IDLE;
                  r_k_valid <= 1'b0;
                  r_busy    <= 1'b0;
               end else if (!bus.stall) begin
                  if (r_round_idx == c_last_idx) begin
                     r_state     <= S_IDLE;
                     r_k_valid   <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_round_idx <= '0;
                  end else begin
                     r_round_idx <= r_round_idx + IDX_W'(1);
                     r_k_out     <= w_rom_k;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.k_out     = r_k_out;
   assign bus.round_idx = r_round_idx;
   assign bus.k_valid   = r_k_valid;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sha2_k_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sha2_k_sequencer : bench for 32- and 64-bit K sequencers       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_sha2_k_sequencer;
   logic clk;
   logic rst;

   sha2_k_sequencer_if #(.WORD_W(32), .IDX_W(7)) b32 ();
   sha2_k_sequencer_if #(.WORD_W(64), .IDX_W(7)) b64 ();

   sha2_k_sequencer #(.WORD_W(32), .IDX_W(7)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
   sha2_k_sequencer #(.WORD_W(64), .IDX_W(7)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] K256 [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   typedef struct {
      int          idx;
      logic [63:0] k;
   } exp_t;

   typedef struct {
      bit          w64;
      logic [6:0]  addr;
      logic [63:0] exp_k;
   } rd_vec_t;

   exp_t        q32[$];
   exp_t        q64[$];
   logic [63:0] qrd32[$];
   logic [63:0] qrd64[$];
   rd_vec_t     vecs[10];
   exp_t        e32;
   exp_t        e64;
   int          n_err;
   int          n_checks;
   bit          mon_en;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] kref(input bit w64, input int i);
      if (i < 0 || i >= (w64 ? 80 : 64)) return '1;
      return w64 ? K512[i] : {32'd0, K256[i]};
   endfunction

   function automatic logic get_kvalid(input bit w64);
      return w64 ? b64.k_valid : b32.k_valid;
   endfunction

   function automatic int get_idx(input bit w64);
      return w64 ? int'(b64.round_idx) : int'(b32.round_idx);
   endfunction

   function automatic logic [63:0] get_k(input bit w64);
      return w64 ? b64.k_out : {32'd0, b32.k_out};
   endfunction

   function automatic logic get_busy(input bit w64);
      return w64 ? b64.busy : b32.busy;
   endfunction

   function automatic logic get_done(input bit w64);
      return w64 ? b64.done : b32.done;
   endfunction

   task automatic drive(input bit w64, input logic s, input logic a);
      if (w64) begin
         b64.stall = s;
         b64.abort = a;
      end else begin
         b32.stall = s;
         b32.abort = a;
      end
   endtask

   // Scoreboard: a constant is consumed on an edge where k_valid=1, stall=0, abort=0.
   always @(negedge clk) begin
      if (mon_en) begin
         if (b32.k_valid && !b32.stall && !b32.abort && !rst) begin
            if (q32.size() == 0) chk("sb32_extra_constant", b32.k_valid, 1'b0);
            else begin
               e32 = q32.pop_front();
               chk("sb32_idx", b32.round_idx, e32.idx);
               chk("sb32_k", b32.k_out, e32.k);
            end
         end
         if (b64.k_valid && !b64.stall && !b64.abort && !rst) begin
            if (q64.size() == 0) chk("sb64_extra_constant", b64.k_valid, 1'b0);
            else begin
               e64 = q64.pop_front();
               chk("sb64_idx", b64.round_idx, e64.idx);
               chk("sb64_k", b64.k_out, e64.k);
            end
         end
         if (b32.rd_valid) begin
            if (qrd32.size() == 0) chk("rd32_unexpected", b32.rd_valid, 1'b0);
            else chk("rd32_k", b32.k_out, qrd32.pop_front());
         end
         if (b64.rd_valid) begin
            if (qrd64.size() == 0) chk("rd64_unexpected", b64.rd_valid, 1'b0);
            else chk("rd64_k", b64.k_out, qrd64.pop_front());
         end
         chk("inv32_valid_excl", b32.k_valid & b32.rd_valid, 0);
         chk("inv64_valid_excl", b64.k_valid & b64.rd_valid, 0);
         chk("inv32_done_busy", b32.done & b32.busy, 0);
         chk("inv64_done_busy", b64.done & b64.busy, 0);
         if (b32.k_valid) chk("inv32_k_eq_ref", b32.k_out, kref(1'b0, int'(b32.round_idx)));
         if (b64.k_valid) chk("inv64_k_eq_ref", b64.k_out, kref(1'b1, int'(b64.round_idx)));
      end
   end

   task automatic run_stream(input bit w64, input int stall_at, input int stall_len,
                             input int abort_at, input int rst_at,
                             input int exp_len, input bit exp_done);
      int   n;
      int   nvalid;
      int   nstall;
      int   nheld;
      int   left;
      int   c;
      exp_t e;
      n = w64 ? 80 : 64;
      for (int i = 0; i < n; i++) begin
         e.idx = i;
         e.k   = kref(w64, i);
         if (w64) q64.push_back(e);
         else     q32.push_back(e);
      end
      if (w64) b64.start = 1'b1;
      else     b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      b64.start = 1'b0;
      nvalid = 0;
      nstall = 0;
      nheld  = 0;
      c      = 0;
      while (get_kvalid(w64) && c < 300) begin
         c++;
         nvalid++;
         if (get_idx(w64) == stall_at) nheld++;
         if (get_idx(w64) == abort_at) begin
            drive(w64, 1'b1, 1'b1);
         end else if (get_idx(w64) == rst_at) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
            #1;
            chk("rst_midcycle_k_valid", get_kvalid(w64), 1'b1);
            chk("rst_midcycle_idx", get_idx(w64), rst_at);
            rst = 1'b1;
         end else if (get_idx(w64) == stall_at && nstall < stall_len) begin
            drive(w64, 1'b1, 1'b0);
            nstall++;
         end else begin
            drive(w64, 1'b0, 1'b0);
         end
         tick();
      end
      chk("stream_len", nvalid, exp_len);
      chk("stream_stopped", get_kvalid(w64), 1'b0);
      chk("busy_low_after", get_busy(w64), 1'b0);
      chk("done_pulse", get_done(w64), exp_done);
      if (abort_at >= 0) begin
         chk("abort_k_held", get_k(w64), kref(w64, abort_at));
         left = n - abort_at;
      end else if (rst_at >= 0) begin
         chk("rst_k_zero", get_k(w64), 0);
         chk("rst_idx_zero", get_idx(w64), 0);
         left = n - rst_at;
      end else begin
         chk("final_k_held", get_k(w64), kref(w64, n - 1));
         chk("final_idx_zero", get_idx(w64), 0);
         left = 0;
      end
      if (stall_at >= 0) chk("stall_hold_cycles", nheld, stall_len + 1);
      chk("sb_left", w64 ? q64.size() : q32.size(), left);
      q32.delete();
      q64.delete();
      rst = 1'b0;
      drive(w64, 1'b0, 1'b0);
      b32.rd = 1'b0;
      b64.rd = 1'b0;
      tick();
      chk("done_one_cycle", get_done(w64), 1'b0);
      chk("idle_busy", get_busy(w64), 1'b0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 7'd10,  64'h00000000243185be};
      vecs[1] = '{1'b0, 7'd0,   64'h00000000428a2f98};
      vecs[2] = '{1'b0, 7'd63,  64'h00000000c67178f2};
      vecs[3] = '{1'b0, 7'd64,  64'h0};
      vecs[4] = '{1'b0, 7'd127, 64'h0};
      vecs[5] = '{1'b0, 7'd37,  64'h00000000766a0abb};
      vecs[6] = '{1'b1, 7'd0,   64'h428a2f98d728ae22};
      vecs[7] = '{1'b1, 7'd79,  64'h6c44198c4a475817};
      vecs[8] = '{1'b1, 7'd63,  64'hc67178f2e372532b};
      vecs[9] = '{1'b1, 7'd80,  64'h0};

      n_err = 0;
      n_checks = 0;
      mon_en = 1'b0;
      rst = 1'b1;
      b32.start = 1'b0; b32.stall = 1'b0; b32.abort = 1'b0; b32.rd = 1'b0; b32.addr = '0;
      b64.start = 1'b0; b64.stall = 1'b0; b64.abort = 1'b0; b64.rd = 1'b0; b64.addr = '0;
      repeat (2) tick();

      for (int d = 0; d < 2; d++) begin
         chk("reset_k_out", get_k(d[0]), 0);
         chk("reset_round_idx", get_idx(d[0]), 0);
         chk("reset_k_valid", get_kvalid(d[0]), 1'b0);
         chk("reset_rd_valid", d[0] ? b64.rd_valid : b32.rd_valid, 1'b0);
         chk("reset_busy", get_busy(d[0]), 1'b0);
         chk("reset_done", get_done(d[0]), 1'b0);
      end
      rst = 1'b0;
      mon_en = 1'b1;

      // Random access while idle, with stall/abort asserted to show they are ignored.
      b32.stall = 1'b1;
      b32.abort = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].w64) begin
            b64.rd   = 1'b1;
            b64.addr = vecs[i].addr;
            qrd64.push_back(vecs[i].exp_k);
         end else begin
            b32.rd   = 1'b1;
            b32.addr = vecs[i].addr;
            qrd32.push_back(vecs[i].exp_k);
         end
         tick();
         b32.rd = 1'b0;
         b64.rd = 1'b0;
         tick();
      end
      b32.stall = 1'b0;
      b32.abort = 1'b0;
      tick();
      chk("rd_queue32_drained", qrd32.size(), 0);
      chk("rd_queue64_drained", qrd64.size(), 0);
      chk("rd_idx_untouched", b32.round_idx, 0);
      chk("rd_kvalid_untouched", b32.k_valid, 1'b0);

      // Full 32-bit stream with rd held high: start wins, rd ignored while busy.
      b32.rd   = 1'b1;
      b32.addr = 7'd10;
      run_stream(1'b0, -1, 0, -1, -1, 64, 1'b1);
      run_stream(1'b1, -1, 0, -1, -1, 80, 1'b1);
      run_stream(1'b0, 5, 3, -1, -1, 67, 1'b1);
      run_stream(1'b0, -1, 0, 20, -1, 21, 1'b0);
      run_stream(1'b0, -1, 0, -1, -1, 64, 1'b1);
      run_stream(1'b0, -1, 0, -1, 40, 41, 1'b0);
      run_stream(1'b0, -1, 0, -1, -1, 64, 1'b1);
      chk("rd_queue32_final", qrd32.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
